// File: rtl/banco_registradores8.sv
// banco_registradores8 - eight-word register bank (RAM8 stage).
// Each bit of carga loads one word. A write is accepted only when exactly
// one load line is high. Multi-hot patterns are rejected and raise a sticky
// error flag. The read path is registered with one cycle of latency. An
// accepted write to the word being read is forwarded directly to the output.
module banco_registradores8 #(
    parameter int LARGURA      = 16,
    parameter int LARGURA_CONT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              carga,
    input  logic [LARGURA-1:0]      dado_entrada,
    input  logic [2:0]              endereco_leitura,
    output logic [LARGURA-1:0]      dado_saida,
    output logic                    saida_valida,
    output logic                    erro_onehot,
    output logic [LARGURA_CONT-1:0] contagem_escritas
);

    localparam logic [LARGURA_CONT-1:0] CONT_MAX = {LARGURA_CONT{1'b1}};

    logic [LARGURA-1:0] registradores [8];
    logic [7:0]         escrito;

    logic carga_nao_nula;
    logic carga_unica;
    logic carga_multipla;
    logic bypass;

    // Classify the load pattern. A nonzero value with a single set bit is
    // one-hot. The expression x & (x - 1) is zero only when x has at most
    // one set bit.
    always_comb begin
        carga_nao_nula = |carga;
        carga_unica    = carga_nao_nula && ((carga & (carga - 8'd1)) == 8'd0);
        carga_multipla = carga_nao_nula && !carga_unica;
        bypass         = carga_unica && carga[endereco_leitura];
    end

    // Storage, written flags, error flag, counter and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                registradores[i] <= '0;
            end
            escrito           <= '0;
            dado_saida        <= '0;
            saida_valida      <= 1'b0;
            erro_onehot       <= 1'b0;
            contagem_escritas <= '0;
        end else begin
            if (carga_unica) begin
                for (int i = 0; i < 8; i++) begin
                    if (carga[i]) begin
                        registradores[i] <= dado_entrada;
                        escrito[i]       <= 1'b1;
                    end
                end
                if (contagem_escritas != CONT_MAX) begin
                    contagem_escritas <= contagem_escritas + 1'b1;
                end
            end

            if (carga_multipla) begin
                erro_onehot <= 1'b1;
            end

            if (bypass) begin
                dado_saida   <= dado_entrada;
                saida_valida <= 1'b1;
            end else begin
                dado_saida   <= registradores[endereco_leitura];
                saida_valida <= escrito[endereco_leitura];
            end
        end
    end

endmodule

// File: tb/tb_banco_registradores8.sv
// Self-checking bench for banco_registradores8.
// Two instances share their inputs. The first uses the default counter
// width. The second uses a 3-bit counter to exercise saturation. A
// behavioural model computes the expected outputs for each cycle and pushes
// them to a queue. The entries are popped and compared after the edge.
module tb_banco_registradores8;

    logic        clk;
    logic        reset;
    logic [7:0]  carga;
    logic [15:0] dado_entrada;
    logic [2:0]  endereco_leitura;

    logic [15:0] dado_saida;
    logic        saida_valida;
    logic        erro_onehot;
    logic [7:0]  contagem_escritas;

    logic [15:0] dado_saida_s;
    logic        saida_valida_s;
    logic        erro_onehot_s;
    logic [2:0]  contagem_escritas_s;

    banco_registradores8 #(.LARGURA(16), .LARGURA_CONT(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .carga             (carga),
        .dado_entrada      (dado_entrada),
        .endereco_leitura  (endereco_leitura),
        .dado_saida        (dado_saida),
        .saida_valida      (saida_valida),
        .erro_onehot       (erro_onehot),
        .contagem_escritas (contagem_escritas)
    );

    banco_registradores8 #(.LARGURA(16), .LARGURA_CONT(3)) dut_sat (
        .clk               (clk),
        .reset             (reset),
        .carga             (carga),
        .dado_entrada      (dado_entrada),
        .endereco_leitura  (endereco_leitura),
        .dado_saida        (dado_saida_s),
        .saida_valida      (saida_valida_s),
        .erro_onehot       (erro_onehot_s),
        .contagem_escritas (contagem_escritas_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dado;
        logic        valida;
        logic        erro;
        int          cont;
        int          cont3;
    } esperado_t;

    esperado_t fila[$];

    logic [15:0] m_reg [8];
    logic        m_escrito [8];
    logic        m_erro;
    int          m_cont;
    int          m_cont3;

    int n_checks = 0;
    int n_erros  = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Drive one cycle and let the model predict the result. After the edge,
    // pop the prediction and compare it against both instances.
    task automatic ciclo(input logic r, input logic [7:0] c, input logic [15:0] d, input logic [2:0] a);
        esperado_t e;
        int        pc;
        reset            = r;
        carga            = c;
        dado_entrada     = d;
        endereco_leitura = a;
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i]     = '0;
                m_escrito[i] = 1'b0;
            end
            m_erro  = 1'b0;
            m_cont  = 0;
            m_cont3 = 0;
            e.dado   = '0;
            e.valida = 1'b0;
        end else begin
            pc = $countones(c);
            if (pc == 1 && c[a]) begin
                e.dado   = d;
                e.valida = 1'b1;
            end else begin
                e.dado   = m_reg[a];
                e.valida = m_escrito[a];
            end
            if (pc == 1) begin
                for (int i = 0; i < 8; i++) begin
                    if (c[i]) begin
                        m_reg[i]     = d;
                        m_escrito[i] = 1'b1;
                    end
                end
                if (m_cont < 255) m_cont++;
                if (m_cont3 < 7) m_cont3++;
            end else if (pc > 1) begin
                m_erro = 1'b1;
            end
        end
        e.erro  = m_erro;
        e.cont  = m_cont;
        e.cont3 = m_cont3;
        fila.push_back(e);

        @(posedge clk);
        #1;
        if (fila.size() == 0) begin
            verifica("fila_vazia", 32'd0, 32'd1);
        end else begin
            e = fila.pop_front();
            verifica("dado_saida",   32'(dado_saida),          32'(e.dado));
            verifica("saida_valida", 32'(saida_valida),        32'(e.valida));
            verifica("erro_onehot",  32'(erro_onehot),         32'(e.erro));
            verifica("contagem",     32'(contagem_escritas),   32'(e.cont));
            verifica("dado_sat",     32'(dado_saida_s),        32'(e.dado));
            verifica("contagem_sat", 32'(contagem_escritas_s), 32'(e.cont3));
        end
    endtask

    initial begin
        reset = 1'b0; carga = '0; dado_entrada = '0; endereco_leitura = '0;
        @(negedge clk);

        // Reset, then read every address.
        ciclo(1'b1, 8'h00, 16'h0000, 3'd0);
        verifica("rst_dado", 32'(dado_saida), 32'h0);
        verifica("rst_cont", 32'(contagem_escritas), 32'h0);
        for (int k = 0; k < 8; k++) ciclo(1'b0, 8'h00, 16'h0000, 3'(k));

        // Sweep of single writes, followed by reads of every address.
        for (int i = 0; i < 8; i++) ciclo(1'b0, 8'(1 << i), 16'(16'h1000 + i), 3'd7);
        for (int k = 0; k < 8; k++) begin
            ciclo(1'b0, 8'h00, 16'h0000, 3'(k));
            verifica("varre_dado", 32'(dado_saida), 32'(16'h1000 + k));
            verifica("varre_valida", 32'(saida_valida), 32'd1);
        end
        verifica("cont_8", 32'(contagem_escritas), 32'd8);
        verifica("sat_apos_8", 32'(contagem_escritas_s), 32'd7);

        // Write-through bypass.
        ciclo(1'b0, 8'b0010_0000, 16'hBEEF, 3'd5);
        verifica("bypass_dado", 32'(dado_saida), 32'hBEEF);
        verifica("bypass_valida", 32'(saida_valida), 32'd1);

        // Multi-hot rejection. The stored value is returned, with no bypass.
        ciclo(1'b0, 8'b0000_0011, 16'hDEAD, 3'd0);
        verifica("multi_dado", 32'(dado_saida), 32'h1000);
        verifica("multi_erro", 32'(erro_onehot), 32'd1);
        verifica("multi_cont", 32'(contagem_escritas), 32'd9);
        ciclo(1'b0, 8'b0000_0010, 16'h1234, 3'd1);
        verifica("erro_sticky", 32'(erro_onehot), 32'd1);
        ciclo(1'b0, 8'h00, 16'h0000, 3'd0);
        verifica("multi_nao_gravou", 32'(dado_saida), 32'h1000);

        // Counter saturation on the 3-bit instance.
        ciclo(1'b1, 8'h00, 16'h0000, 3'd0);
        for (int j = 0; j < 10; j++) ciclo(1'b0, 8'(1 << (j % 8)), 16'(j), 3'd2);
        verifica("sat_7", 32'(contagem_escritas_s), 32'd7);
        verifica("cont_10", 32'(contagem_escritas), 32'd10);

        // Reset in the middle of operation, coincident with a write.
        ciclo(1'b0, 8'b0000_0011, 16'h0000, 3'd0);
        ciclo(1'b0, 8'b1000_0000, 16'hAAAA, 3'd0);
        ciclo(1'b1, 8'b1000_0000, 16'h5555, 3'd7);
        ciclo(1'b0, 8'h00, 16'h0000, 3'd7);
        verifica("rst_meio_dado", 32'(dado_saida), 32'h0);
        verifica("rst_meio_valida", 32'(saida_valida), 32'd0);
        verifica("rst_meio_cont", 32'(contagem_escritas), 32'd0);
        verifica("rst_meio_erro", 32'(erro_onehot), 32'd0);

        // Random traffic that mixes idle, one-hot and multi-hot patterns.
        for (int n = 0; n < 60; n++) begin
            logic [7:0] c;
            case ($urandom_range(0, 3))
                0:       c = 8'h00;
                1, 2:    c = 8'(1 << $urandom_range(0, 7));
                default: c = 8'($urandom_range(0, 255));
            endcase
            ciclo(1'b0, c, 16'($urandom), 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

endmodule
